// File: rtl/instr_mem_loader.sv
// Instruction memory with a byte-stream program loader and a registered, 1-cycle fetch port.
// Loader packs little-endian bytes into words written sequentially from word 0.
module instr_mem_loader #(
  parameter int          ADDR_BITS = 5,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 LD_START,
  input  logic                 LD_VALID,
  input  logic [7:0]           LD_BYTE,
  input  logic                 LD_LAST,
  output logic                 LD_READY,
  output logic                 LD_DONE,
  output logic                 LD_ERR,
  output logic [ADDR_BITS:0]   LD_WORDS,
  input  logic                 FETCH_EN,
  input  logic [31:0]          PC,
  output logic [31:0]          INSTRUCTION,
  output logic                 MISALIGNED,
  output logic                 OUT_OF_RANGE
);
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS:0]   words_q, words_d;
  logic [1:0]           idx_q, idx_d;
  logic [31:0]          word_q, word_d;
  logic                 err_q, err_d;
  logic [31:0]          instr_q, instr_d;
  logic                 mis_q, mis_d;
  logic                 oor_q, oor_d;

  logic [31:0]          mem [DEPTH];
  logic                 we;
  logic [31:0]          merged;
  logic                 accept;
  logic                 complete;
  logic                 mis_c;
  logic                 oor_c;
  logic [31:0]          rdata;

  always_comb begin
    state_d  = state_q;
    words_d  = words_q;
    idx_d    = idx_q;
    word_d   = word_q;
    err_d    = err_q;
    instr_d  = instr_q;
    mis_d    = mis_q;
    oor_d    = oor_q;
    we       = 1'b0;

    // A fresh word starts from zero so a short final word has zero-filled upper lanes.
    merged = (idx_q == 2'd0) ? 32'h0 : word_q;
    case (idx_q)
      2'd0:    merged[7:0]   = LD_BYTE;
      2'd1:    merged[15:8]  = LD_BYTE;
      2'd2:    merged[23:16] = LD_BYTE;
      default: merged[31:24] = LD_BYTE;
    endcase
    accept   = (state_q == LOAD) && LD_VALID;
    complete = accept && ((idx_q == 2'd3) || LD_LAST);

    case (state_q)
      IDLE, DONE: begin
        if (LD_START) begin
          state_d = LOAD;
          words_d = '0;
          idx_d   = 2'd0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          word_d = merged;
          idx_d  = idx_q + 2'd1;
          if (complete) begin
            // words_q doubles as the write pointer; its MSB set means memory is full.
            if (words_q[ADDR_BITS]) begin
              err_d = 1'b1;
            end else begin
              we      = 1'b1;
              words_d = words_q + 1'b1;
            end
          end
          if (LD_LAST) begin
            state_d = DONE;
            idx_d   = 2'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    mis_c = (PC[1:0] != 2'b00);
    oor_c = |PC[31:ADDR_BITS+2];
    rdata = mem[PC[ADDR_BITS+1:2]];
    if (FETCH_EN) begin
      mis_d   = mis_c;
      oor_d   = oor_c;
      instr_d = ((state_q == LOAD) || mis_c || oor_c) ? NOP_WORD : rdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      words_q <= '0;
      idx_q   <= 2'd0;
      err_q   <= 1'b0;
      instr_q <= NOP_WORD;
      mis_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      instr_q <= instr_d;
      mis_q   <= mis_d;
      oor_q   <= oor_d;
    end
  end

  // Partial-word buffer and memory contents survive reset.
  always_ff @(posedge CLK) begin
    word_q <= word_d;
    if (we) mem[words_q[ADDR_BITS-1:0]] <= merged;
  end

  assign LD_READY     = (state_q == LOAD);
  assign LD_DONE      = (state_q == DONE);
  assign LD_ERR       = err_q;
  assign LD_WORDS     = words_q;
  assign INSTRUCTION  = instr_q;
  assign MISALIGNED   = mis_q;
  assign OUT_OF_RANGE = oor_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: load, fetch, overflow, flags, stalls and mid-load reset.
module tb_instr_mem_loader;
  localparam int AB    = 5;
  localparam int DEPTH = 1 << AB;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          LD_START = 1'b0;
  logic          LD_VALID = 1'b0;
  logic [7:0]    LD_BYTE = 8'h00;
  logic          LD_LAST = 1'b0;
  logic          LD_READY;
  logic          LD_DONE;
  logic          LD_ERR;
  logic [AB:0]   LD_WORDS;
  logic          FETCH_EN = 1'b0;
  logic [31:0]   PC = 32'h0;
  logic [31:0]   INSTRUCTION;
  logic          MISALIGNED;
  logic          OUT_OF_RANGE;

  int total = 0;
  int bad   = 0;

  instr_mem_loader #(.ADDR_BITS(AB), .NOP_WORD(NOP)) dut (
    .CLK(CLK), .RST(RST), .LD_START(LD_START), .LD_VALID(LD_VALID), .LD_BYTE(LD_BYTE),
    .LD_LAST(LD_LAST), .LD_READY(LD_READY), .LD_DONE(LD_DONE), .LD_ERR(LD_ERR),
    .LD_WORDS(LD_WORDS), .FETCH_EN(FETCH_EN), .PC(PC), .INSTRUCTION(INSTRUCTION),
    .MISALIGNED(MISALIGNED), .OUT_OF_RANGE(OUT_OF_RANGE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start();
    LD_START = 1'b1;
    tick();
    LD_START = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    LD_VALID = 1'b1;
    LD_BYTE  = b;
    LD_LAST  = last;
    tick();
    LD_VALID = 1'b0;
    LD_LAST  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc);
    FETCH_EN = 1'b1;
    PC       = pc;
    tick();
    FETCH_EN = 1'b0;
  endtask

  initial begin
    // reset state
    tick(); tick();
    RST = 1'b0;
    chk("rst_ready", 32'(LD_READY), 32'd0);
    chk("rst_done", 32'(LD_DONE), 32'd0);
    chk("rst_err", 32'(LD_ERR), 32'd0);
    chk("rst_words", 32'(LD_WORDS), 32'd0);
    chk("rst_instr", INSTRUCTION, NOP);
    chk("rst_mis", 32'(MISALIGNED), 32'd0);
    chk("rst_oor", 32'(OUT_OF_RANGE), 32'd0);

    // basic two-word program
    start();
    chk("t1_ready", 32'(LD_READY), 32'd1);
    send(8'h13, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    send(8'h93, 1'b0); send(8'h00, 1'b0); send(8'h10, 1'b0); send(8'h00, 1'b1);
    chk("t1_done", 32'(LD_DONE), 32'd1);
    chk("t1_words", 32'(LD_WORDS), 32'd2);
    chk("t1_ready_off", 32'(LD_READY), 32'd0);
    FETCH_EN = 1'b1; PC = 32'd4; #1;
    chk("t1_latency", INSTRUCTION, NOP);
    tick(); FETCH_EN = 1'b0;
    chk("t1_pc4", INSTRUCTION, 32'h0010_0093);
    fetch(32'd0);
    chk("t1_pc0", INSTRUCTION, 32'h0000_0013);

    // partial final word is zero-filled
    start();
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
    send(8'h11, 1'b0); send(8'h22, 1'b1);
    chk("t2_words", 32'(LD_WORDS), 32'd2);
    fetch(32'd0);
    chk("t2_w0", INSTRUCTION, 32'hDDCC_BBAA);
    fetch(32'd4);
    chk("t2_w1", INSTRUCTION, 32'h0000_2211);

    // overflow: DEPTH words plus one extra
    start();
    for (int w = 0; w <= DEPTH; w++) begin
      if (w < DEPTH) begin
        send(8'(w), 1'b0); send(~8'(w), 1'b0); send(8'h3C, 1'b0); send(8'h81, 1'b0);
      end else begin
        send(8'hEE, 1'b0); send(8'hEE, 1'b0); send(8'hEE, 1'b0); send(8'hEE, 1'b1);
      end
    end
    chk("t3_err", 32'(LD_ERR), 32'd1);
    chk("t3_words", 32'(LD_WORDS), 32'(DEPTH));
    chk("t3_done", 32'(LD_DONE), 32'd1);
    fetch(32'd0);
    chk("t3_w0", INSTRUCTION, 32'h813C_FF00);
    fetch(32'(4 * (DEPTH - 1)));
    chk("t3_wlast", INSTRUCTION, 32'h813C_E01F);
    start();
    chk("t3_err_clr", 32'(LD_ERR), 32'd0);
    chk("t3_words_clr", 32'(LD_WORDS), 32'd0);

    // fetch blocked during load, stalled valid mid-word
    fetch(32'd0);
    chk("t5_blocked", INSTRUCTION, NOP);
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    tick(); tick(); tick();
    send(8'h03, 1'b0); send(8'h04, 1'b0);
    send(8'h05, 1'b0); send(8'h06, 1'b0); send(8'h07, 1'b0); send(8'h08, 1'b1);
    chk("t5_words", 32'(LD_WORDS), 32'd2);
    fetch(32'd0);
    chk("t5_w0", INSTRUCTION, 32'h0403_0201);
    fetch(32'd4);
    chk("t5_w1", INSTRUCTION, 32'h0807_0605);

    // misaligned and out-of-range flags
    fetch(32'd6);
    chk("t4_mis_instr", INSTRUCTION, NOP);
    chk("t4_mis", 32'(MISALIGNED), 32'd1);
    chk("t4_mis_oor", 32'(OUT_OF_RANGE), 32'd0);
    fetch(32'(4 * DEPTH));
    chk("t4_oor_instr", INSTRUCTION, NOP);
    chk("t4_oor", 32'(OUT_OF_RANGE), 32'd1);
    chk("t4_oor_mis", 32'(MISALIGNED), 32'd0);
    fetch(32'd4);
    chk("t4_ok_instr", INSTRUCTION, 32'h0807_0605);
    chk("t4_ok_flags", {30'd0, MISALIGNED, OUT_OF_RANGE}, 32'd0);
    PC = 32'd0;
    tick();
    chk("t4_hold", INSTRUCTION, 32'h0807_0605);

    // reset in the middle of a load
    start();
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    send(8'h55, 1'b0); send(8'h66, 1'b0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t6_ready", 32'(LD_READY), 32'd0);
    chk("t6_done", 32'(LD_DONE), 32'd0);
    chk("t6_words", 32'(LD_WORDS), 32'd0);
    chk("t6_instr", INSTRUCTION, NOP);
    fetch(32'd0);
    chk("t6_w0_kept", INSTRUCTION, 32'h4433_2211);
    start();
    send(8'h9A, 1'b0); send(8'hBC, 1'b0); send(8'hDE, 1'b0); send(8'hF0, 1'b1);
    chk("t6_words_new", 32'(LD_WORDS), 32'd1);
    fetch(32'd0);
    chk("t6_w0_new", INSTRUCTION, 32'hF0DE_BC9A);
    fetch(32'd4);
    chk("t6_w1_untouched", INSTRUCTION, 32'h0807_0605);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
